au_op_sequencer: RTL and testbench
==================================

AU_OP_SEQUENCER -- requirements
Module: au_op_sequencer

Interface
REQ-001 SHALL have parameter MD_CYCLES, default 32, which is the number of clocks the arithmetic unit needs to complete a mult or div after its start pulse.
REQ-002 SHALL have parameter W, default 32, which is the operand and result width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: command offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: sequencer can accept a command.
REQ-007 SHALL have port cmd_op, input, 2 bits: 00 ADD, 01 SUB, 10 MULT, 11 DIV.
REQ-008 SHALL have ports cmd_a and cmd_b, input, W bits each: the operands.
REQ-009 SHALL have ports au_a and au_b, output, W bits each: operands driven to the AU.
REQ-010 SHALL have port au_aluop, output, 2 bits: operation code driven to the AU.
REQ-011 SHALL have port au_rst_n, output, 1 bit: active-low AU init/start pulse.
REQ-012 SHALL have ports au_s, au_hi and au_lo, input, W bits each: AU sum, high and low results.
REQ-013 SHALL have port au_zero, input, 1 bit: AU zero flag.
REQ-014 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-015 SHALL have port rsp_ready, input, 1 bit: consumer accepts the result.
REQ-016 SHALL have ports rsp_hi and rsp_lo, output, W bits each: the result.
REQ-017 SHALL have port rsp_zero, output, 1 bit: result-is-zero flag.
REQ-018 SHALL have port rsp_dbz, output, 1 bit: divide-by-zero flag.

Function
REQ-019 SHALL implement states IDLE, START, WAIT, CAPT and RESP, with at most one operation in flight.
REQ-020 SHALL drive cmd_ready=1 only in IDLE while rst=0; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-021 SHALL, on acceptance, register cmd_op, cmd_a and cmd_b onto au_aluop, au_a and au_b, and hold them stable until the next acceptance.
REQ-022 SHALL, for accepted DIV with cmd_b==0, bypass the AU and go IDLE->RESP with rsp_hi=cmd_a, rsp_lo={W{1}}, rsp_zero=0, rsp_dbz=1.
REQ-023 SHALL, for any other accepted command, go IDLE->START; START lasts exactly 1 cycle with au_rst_n=0, and au_rst_n=1 in every other state.
REQ-024 SHALL, from START, go to CAPT for ADD/SUB and to WAIT with the counter cleared for MULT/DIV.
REQ-025 SHALL, in WAIT, count for MD_CYCLES cycles and then go to CAPT.
REQ-026 SHALL, in CAPT, load the response registers and then go to RESP.
REQ-027 SHALL, in CAPT for ADD/SUB, load rsp_hi=0, rsp_lo=au_s, rsp_zero=au_zero and rsp_dbz=0.
REQ-028 SHALL, in CAPT for MULT/DIV, load rsp_hi=au_hi and rsp_lo=au_lo, set rsp_zero=1 only when both au_hi and au_lo are zero, and set rsp_dbz=0.
REQ-029 SHALL assert rsp_valid only in RESP; rsp_* SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-030 SHALL leave RESP for IDLE on the edge where rsp_valid and rsp_ready are both 1; cmd_ready rises the following cycle, so no same-cycle turnaround.
REQ-031 SHALL assert rsp_valid exactly L clocks after the accepting edge: L=3 for ADD/SUB, L=MD_CYCLES+3 for MULT/DIV, L=1 for divide-by-zero.
REQ-032 SHALL pass operands and results unmodified, with no sign handling, so that ALU semantics belong to the AU.
REQ-033 SHALL use a counter of $clog2(MD_CYCLES+1) bits that never wraps in WAIT.
REQ-034 SHALL ignore cmd_valid outside IDLE and ignore rsp_ready outside RESP.

Reset
REQ-035 SHALL, on any edge with rst=1, set state=IDLE, rsp_valid=0, rsp_hi=0, rsp_lo=0, rsp_zero=0, rsp_dbz=0, au_a=0, au_b=0, au_aluop=00 and counter=0.
REQ-036 SHALL hold au_rst_n=0 and cmd_ready=0 combinationally while rst=1.
REQ-037 SHALL, when rst is asserted mid-operation in START, WAIT, CAPT or RESP, abandon the in-flight operation with no response produced.
REQ-038 SHALL accept a new command in the first cycle after rst deasserts.

Verification
REQ-039 SHALL be verified with ADD a=7, b=3 -> rsp_lo=10, rsp_hi=0, rsp_zero=0, rsp_valid 3 clocks after acceptance.
REQ-040 SHALL be verified with SUB a=5, b=5 -> rsp_lo=0, rsp_zero=1; au_rst_n low for exactly 1 cycle.
REQ-041 SHALL be verified with MULT a=0x0001_0000, b=0x0001_0000 -> rsp_hi=1, rsp_lo=0, rsp_valid at 35 clocks; cmd_ready=0 throughout.
REQ-042 SHALL be verified with DIV a=7, b=3 -> rsp_lo=2, rsp_hi=1 at 35 clocks; then DIV a=9, b=0 -> rsp_dbz=1, rsp_hi=9, rsp_lo=0xFFFF_FFFF at 1 clock, and au_rst_n never pulses.
REQ-043 SHALL be verified with rsp_ready held 0 for 5 cycles after rsp_valid -> all rsp_* stable and cmd_ready=0; after handshake, cmd_ready=1 the next cycle.
REQ-044 SHALL be verified with rst pulsed at WAIT count 10 of a MULT -> rsp_valid never rises, all outputs at reset values, and a following ADD 1+1 returns 2 at L=3.

Source files
------------

// File: rtl/au_op_sequencer.sv
// Command/response sequencer for a multi-cycle arithmetic unit (AU).
// It issues one operation at a time, waits out the AU latency, then captures and presents the result.
module au_op_sequencer #(
   parameter int MD_CYCLES = 32,
   parameter int W         = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic [1:0]   cmd_op,
   input  logic [W-1:0] cmd_a,
   input  logic [W-1:0] cmd_b,
   output logic [W-1:0] au_a,
   output logic [W-1:0] au_b,
   output logic [1:0]   au_aluop,
   output logic         au_rst_n,
   input  logic [W-1:0] au_s,
   input  logic [W-1:0] au_hi,
   input  logic [W-1:0] au_lo,
   input  logic         au_zero,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_hi,
   output logic [W-1:0] rsp_lo,
   output logic         rsp_zero,
   output logic         rsp_dbz
);

   localparam int            CW       = $clog2(MD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MD_CYCLES - 1);
   localparam logic [1:0]    OP_DIV   = 2'b11;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [1:0]     op_q, op_d;
   logic [W-1:0]   rsp_hi_q, rsp_hi_d, rsp_lo_q, rsp_lo_d;
   logic           rsp_zero_q, rsp_zero_d, rsp_dbz_q, rsp_dbz_d;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      rsp_hi_d   = rsp_hi_q;
      rsp_lo_d   = rsp_lo_q;
      rsp_zero_d = rsp_zero_q;
      rsp_dbz_d  = rsp_dbz_q;
      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               a_d  = cmd_a;
               b_d  = cmd_b;
               op_d = cmd_op;
               // Divide-by-zero never reaches the AU; the response is synthesised here.
               if (cmd_op == OP_DIV && cmd_b == '0) begin
                  rsp_hi_d   = cmd_a;
                  rsp_lo_d   = '1;
                  rsp_zero_d = 1'b0;
                  rsp_dbz_d  = 1'b1;
                  state_d    = RESP;
               end else begin
                  state_d = START;
               end
            end
         end
         START: begin
            if (op_q[1]) begin
               cnt_d   = '0;
               state_d = WAIT;
            end else begin
               state_d = CAPT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) state_d = CAPT;
         end
         CAPT: begin
            if (op_q[1]) begin
               rsp_hi_d   = au_hi;
               rsp_lo_d   = au_lo;
               rsp_zero_d = (au_hi == '0) && (au_lo == '0);
            end else begin
               rsp_hi_d   = '0;
               rsp_lo_d   = au_s;
               rsp_zero_d = au_zero;
            end
            rsp_dbz_d = 1'b0;
            state_d   = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         op_q       <= 2'b00;
         rsp_hi_q   <= '0;
         rsp_lo_q   <= '0;
         rsp_zero_q <= 1'b0;
         rsp_dbz_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         rsp_hi_q   <= rsp_hi_d;
         rsp_lo_q   <= rsp_lo_d;
         rsp_zero_q <= rsp_zero_d;
         rsp_dbz_q  <= rsp_dbz_d;
      end
   end

   assign cmd_ready = !rst && (state_q == IDLE);
   assign au_rst_n  = !rst && (state_q != START);
   assign au_a      = a_q;
   assign au_b      = b_q;
   assign au_aluop  = op_q;
   assign rsp_valid = (state_q == RESP);
   assign rsp_hi    = rsp_hi_q;
   assign rsp_lo    = rsp_lo_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_dbz   = rsp_dbz_q;

endmodule

// File: tb/tb_au_op_sequencer.sv
// Directed bench for au_op_sequencer with a behavioural AU whose results only become valid after MD_CYCLES.
module tb_au_op_sequencer;

   localparam int W  = 32;
   localparam int MD = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         cmd_valid, cmd_ready;
   logic [1:0]   cmd_op;
   logic [W-1:0] cmd_a, cmd_b;
   logic [W-1:0] au_a, au_b;
   logic [1:0]   au_aluop;
   logic         au_rst_n;
   logic [W-1:0] au_s, au_hi, au_lo;
   logic         au_zero;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_hi, rsp_lo;
   logic         rsp_zero, rsp_dbz;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   au_op_sequencer #(.MD_CYCLES(MD), .W(W)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_a(cmd_a), .cmd_b(cmd_b),
      .au_a(au_a), .au_b(au_b), .au_aluop(au_aluop), .au_rst_n(au_rst_n),
      .au_s(au_s), .au_hi(au_hi), .au_lo(au_lo), .au_zero(au_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_hi(rsp_hi), .rsp_lo(rsp_lo), .rsp_zero(rsp_zero), .rsp_dbz(rsp_dbz)
   );

   // Behavioural AU: mult/div results read as garbage until MD cycles after the start pulse.
   int          au_cnt = 0;
   logic [63:0] prod;
   always @(posedge clk) begin
      if (!au_rst_n) au_cnt <= 0;
      else if (au_cnt < MD) au_cnt <= au_cnt + 1;
   end
   assign prod = {32'b0, au_a} * {32'b0, au_b};
   always_comb begin
      au_s    = (au_aluop == 2'b01) ? (au_a - au_b) : (au_a + au_b);
      au_zero = (au_s == '0);
      au_hi   = 32'hDEAD_BEEF;
      au_lo   = 32'hDEAD_BEEF;
      if (au_cnt >= MD) begin
         if (au_aluop == 2'b10) begin
            au_hi = prod[63:32];
            au_lo = prod[31:0];
         end else if (au_aluop == 2'b11 && au_b != '0) begin
            au_hi = au_a % au_b;
            au_lo = au_a / au_b;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int exp_l, input int exp_pulses, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic ez, input logic ed, input int hold);
      int L;
      int pulses;
      bit rdy_seen;
      @(negedge clk);
      chk({tag, " cmd_ready before"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      @(posedge clk);
      L        = 0;
      pulses   = 0;
      rdy_seen = 1'b0;
      while (1) begin
         L++;
         @(negedge clk);
         cmd_valid = 1'b0;
         if (!au_rst_n) pulses++;
         if (cmd_ready) rdy_seen = 1'b1;
         if (rsp_valid || L > 200) break;
         @(posedge clk);
      end
      chk({tag, " latency"}, 64'(L), 64'(exp_l));
      chk({tag, " au_rst_n pulses"}, 64'(pulses), 64'(exp_pulses));
      chk({tag, " cmd_ready busy"}, 64'(rdy_seen), 64'd0);
      chk({tag, " rsp_hi"}, 64'(rsp_hi), 64'(ehi));
      chk({tag, " rsp_lo"}, 64'(rsp_lo), 64'(elo));
      chk({tag, " rsp_zero"}, 64'(rsp_zero), 64'(ez));
      chk({tag, " rsp_dbz"}, 64'(rsp_dbz), 64'(ed));
      chk({tag, " au_aluop"}, 64'(au_aluop), 64'(op));
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1;
         cmd_op    = 2'b01;
         cmd_a     = ~a;
         @(posedge clk);
         @(negedge clk);
         chk({tag, " hold rsp_valid"}, 64'(rsp_valid), 64'd1);
         chk({tag, " hold rsp_hi"}, 64'(rsp_hi), 64'(ehi));
         chk({tag, " hold rsp_lo"}, 64'(rsp_lo), 64'(elo));
         chk({tag, " hold flags"}, 64'({rsp_zero, rsp_dbz}), 64'({ez, ed}));
         chk({tag, " hold cmd_ready"}, 64'(cmd_ready), 64'd0);
      end
      cmd_valid = 1'b0;
      chk({tag, " au_a held"}, 64'(au_a), 64'(a));
      chk({tag, " au_b held"}, 64'(au_b), 64'(b));
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      chk({tag, " rsp_valid after hs"}, 64'(rsp_valid), 64'd0);
      chk({tag, " cmd_ready after hs"}, 64'(cmd_ready), 64'd1);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'd0);
      chk({tag, " rsp_hi/lo"}, {rsp_hi, rsp_lo}, 64'd0);
      chk({tag, " rsp flags"}, 64'({rsp_zero, rsp_dbz}), 64'd0);
      chk({tag, " au_a/b"}, {au_a, au_b}, 64'd0);
      chk({tag, " au_aluop"}, 64'(au_aluop), 64'd0);
      chk({tag, " au_rst_n"}, 64'(au_rst_n), 64'd1);
      chk({tag, " cmd_ready"}, 64'(cmd_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time, %0d checks, %0d errors", n_checks, n_err);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_a     = '0;
      cmd_b     = '0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst au_rst_n", 64'(au_rst_n), 64'd0);
      rst = 1'b0;
      #1;
      chk_reset_vals("init");

      run_op("add7+3", 2'b00, 32'd7, 32'd3, 3, 1, 32'd0, 32'd10, 1'b0, 1'b0, 0);
      run_op("sub5-5", 2'b01, 32'd5, 32'd5, 3, 1, 32'd0, 32'd0, 1'b1, 1'b0, 0);
      run_op("mult", 2'b10, 32'h0001_0000, 32'h0001_0000, MD + 3, 1, 32'd1, 32'd0, 1'b0, 1'b0, 0);
      run_op("mult0", 2'b10, 32'd0, 32'd5, MD + 3, 1, 32'd0, 32'd0, 1'b1, 1'b0, 0);
      run_op("div7/3", 2'b11, 32'd7, 32'd3, MD + 3, 1, 32'd1, 32'd2, 1'b0, 1'b0, 0);
      run_op("div9/0", 2'b11, 32'd9, 32'd0, 1, 0, 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b1, 0);
      run_op("add_bp", 2'b00, 32'h1234_5678, 32'h1111_1111, 3, 1, 32'd0, 32'h2345_6789, 1'b0, 1'b0, 5);

      // Reset lands while the MULT sits at WAIT count 10.
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = 2'b10;
      cmd_a     = 32'd3;
      cmd_b     = 32'd5;
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (11) @(posedge clk);
      @(negedge clk);
      chk("midrst rsp_valid before", 64'(rsp_valid), 64'd0);
      rst = 1'b1;
      #1;
      chk("midrst cmd_ready", 64'(cmd_ready), 64'd0);
      chk("midrst au_rst_n", 64'(au_rst_n), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_reset_vals("midrst");
      run_op("add1+1", 2'b00, 32'd1, 32'd1, 3, 1, 32'd0, 32'd2, 1'b0, 1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
